// File: rtl/bfu_pkg.sv
// Shared types and helpers for the pipelined modular butterfly unit (bfu_pipe).
// Stage records are sized by BFU_DW; bfu_pipe refuses any DATA_WIDTH that differs.
package bfu_pkg;

    localparam int BFU_LATENCY = 3;
    localparam int BFU_DW      = 12;
    localparam int BFU_MOD     = 3329;

    typedef enum logic {
        BFU_CT = 1'b0,
        BFU_GS = 1'b1
    } bfu_mode_e;

    typedef logic [BFU_DW-1:0] bfu_word_t;
    // One extra bit holds sums and differences of two residues, which stay below 2*MOD.
    typedef logic [BFU_DW:0]   bfu_wide_t;

    typedef struct packed {
        logic      valid;
        bfu_mode_e mode;
        bfu_word_t p;
        bfu_word_t w;
        bfu_wide_t s;
        bfu_wide_t d;
    } bfu_s1_t;

    typedef struct packed {
        logic      valid;
        bfu_mode_e mode;
        bfu_wide_t a;
        bfu_wide_t b;
    } bfu_s2_t;

    function automatic bfu_word_t mod_csub(input bfu_wide_t x, input bfu_wide_t m);
        return bfu_word_t'((x >= m) ? x - m : x);
    endfunction

endpackage

// File: rtl/bfu_pipe_if.sv
// Butterfly handshake bundle: operand side (in_*, mode, P/Q/W) and result side (out_*, X0/X1).
// The master modport belongs to the controller; bfu_pipe uses the slave modport.
interface bfu_pipe_if #(
    parameter int DATA_WIDTH = bfu_pkg::BFU_DW
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic                  mode_i;
    logic [DATA_WIDTH-1:0] P_i;
    logic [DATA_WIDTH-1:0] Q_i;
    logic [DATA_WIDTH-1:0] W_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] X0_o;
    logic [DATA_WIDTH-1:0] X1_o;

    modport master (
        output in_valid_i, mode_i, P_i, Q_i, W_i, out_ready_i,
        input  in_ready_o, out_valid_o, X0_o, X1_o
    );

    modport slave (
        input  in_valid_i, mode_i, P_i, Q_i, W_i, out_ready_i,
        output in_ready_o, out_valid_o, X0_o, X1_o
    );
endinterface

// File: rtl/bfu_modmul.sv
// Registered modular multiplier: r_o <= (a_i * b_i) mod MOD, updating only while en_i is high.
// Holds its result when en_i is low, so it stalls in step with the surrounding pipeline.
module bfu_modmul #(
    parameter int DATA_WIDTH = 12,
    parameter int MOD        = 3329
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] r_o
);

    localparam int              PW    = 2 * DATA_WIDTH;
    localparam logic [PW-1:0]   MOD_P = PW'(MOD);

    logic [PW-1:0] prod;

    assign prod = PW'(a_i) * PW'(b_i);

    // NOTE: datapath registers carry no reset; a stage's valid bit alone decides whether its data is used.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            r_o <= DATA_WIDTH'(prod % MOD_P);
        end
    end

endmodule

// File: rtl/bfu_pipe.sv
// Three-stage pipelined CT/GS modular butterfly with valid/ready handshake on both sides.
// Optional BFU_SCALE_EN: GS results are halved mod MOD in S3 (folds the INTT 1/2 factor in).
module bfu_pipe
    import bfu_pkg::*;
#(
    parameter int DATA_WIDTH = BFU_DW,
    parameter int MOD        = BFU_MOD,
    parameter int LATENCY    = BFU_LATENCY
) (
    input  logic       clk_i,
    input  logic       reset_i,
    bfu_pipe_if.slave  bus
);

    if (DATA_WIDTH != BFU_DW || LATENCY != BFU_LATENCY ||
        MOD >= (1 << DATA_WIDTH) || (MOD % 2) == 0) begin : g_bad_cfg
        $error("bfu_pipe: unsupported DATA_WIDTH/MOD/LATENCY combination");
    end

    localparam bfu_wide_t MOD_W = bfu_wide_t'(MOD);

    logic      advance;
    logic      accept;
    bfu_s1_t   s1_q;
    bfu_s2_t   s2_q;
    bfu_s2_t   s2_n;
    bfu_word_t ct_t;
    bfu_word_t gs_b;
    bfu_word_t d_red;
    bfu_word_t x0_n;
    bfu_word_t x1_n;

    // A full S3 that nobody drains is the only thing that stalls the whole pipe.
    assign advance        = !bus.out_valid_o || bus.out_ready_i;
    assign accept         = bus.in_valid_i && advance;
    assign bus.in_ready_o = advance;

    // S1: CT product Q*W is reduced inside the multiplier, aligned with s1_q.
    bfu_modmul #(.DATA_WIDTH(DATA_WIDTH), .MOD(MOD)) u_ct_mul (
        .clk_i (clk_i),
        .en_i  (advance),
        .a_i   (bus.Q_i),
        .b_i   (bus.W_i),
        .r_o   (ct_t)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q.valid <= 1'b0;
        end else if (advance) begin
            s1_q.valid <= accept;
            s1_q.mode  <= bfu_mode_e'(bus.mode_i);
            s1_q.p     <= bus.P_i;
            s1_q.w     <= bus.W_i;
            s1_q.s     <= bfu_wide_t'(bus.P_i) + bfu_wide_t'(bus.Q_i);
            s1_q.d     <= bfu_wide_t'(bus.P_i) + MOD_W - bfu_wide_t'(bus.Q_i);
        end
    end

    // S2: GS difference times twiddle, aligned with s2_q.
    assign d_red = mod_csub(s1_q.d, MOD_W);

    bfu_modmul #(.DATA_WIDTH(DATA_WIDTH), .MOD(MOD)) u_gs_mul (
        .clk_i (clk_i),
        .en_i  (advance),
        .a_i   (d_red),
        .b_i   (s1_q.w),
        .r_o   (gs_b)
    );

    // NOTE: every field gets a default before the mode branch, so no latch is inferred.
    always_comb begin
        s2_n.valid = s1_q.valid;
        s2_n.mode  = s1_q.mode;
        s2_n.a     = s1_q.s;
        s2_n.b     = '0;
        if (s1_q.mode == BFU_CT) begin
            s2_n.a = bfu_wide_t'(s1_q.p) + bfu_wide_t'(ct_t);
            s2_n.b = bfu_wide_t'(s1_q.p) + MOD_W - bfu_wide_t'(ct_t);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s2_q.valid <= 1'b0;
        end else if (advance) begin
            s2_q <= s2_n;
        end
    end

`ifdef BFU_SCALE_EN
    function automatic bfu_word_t mod_half(input bfu_word_t x);
        bfu_wide_t t;
        t = x[0] ? bfu_wide_t'(x) + MOD_W : bfu_wide_t'(x);
        return bfu_word_t'(t >> 1);
    endfunction
`endif

    // S3: final conditional subtract; the GS product is already fully reduced.
    always_comb begin
        x0_n = mod_csub(s2_q.a, MOD_W);
        x1_n = (s2_q.mode == BFU_GS) ? gs_b : mod_csub(s2_q.b, MOD_W);
`ifdef BFU_SCALE_EN
        if (s2_q.mode == BFU_GS) begin
            x0_n = mod_half(x0_n);
            x1_n = mod_half(x1_n);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bus.out_valid_o <= 1'b0;
            bus.X0_o        <= '0;
            bus.X1_o        <= '0;
        end else if (advance) begin
            bus.out_valid_o <= s2_q.valid;
            if (s2_q.valid) begin
                bus.X0_o <= x0_n;
                bus.X1_o <= x1_n;
            end
        end
    end

endmodule

// File: tb/tb_bfu_pipe.sv
// Directed bench for bfu_pipe: vector table with hand-computed results, a scoreboard for
// ordering/duplication, plus stall and mid-flight reset sequences.
module tb_bfu_pipe;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bfu_pipe_if bus ();

    bfu_pipe dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    typedef struct {
        logic        mode;
        logic [11:0] p;
        logic [11:0] q;
        logic [11:0] w;
        logic [11:0] x0;
        logic [11:0] x1;
    } vec_t;

    typedef struct {
        logic [11:0] x0;
        logic [11:0] x1;
    } exp_t;

    vec_t tbl [10];
    exp_t exp_q [$];
    exp_t cur;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_rx  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Unscaled expectations live in the table; the GS halving is applied here when enabled.
    function automatic logic [11:0] scale(input logic mode, input logic [11:0] x);
        logic [12:0] t;
        t = {1'b0, x};
`ifdef BFU_SCALE_EN
        if (mode) begin
            if (x[0]) t = t + 13'd3329;
            t = t >> 1;
        end
`endif
        return t[11:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        bus.in_valid_i = 1'b1;
        bus.mode_i     = tbl[i].mode;
        bus.P_i        = tbl[i].p;
        bus.Q_i        = tbl[i].q;
        bus.W_i        = tbl[i].w;
        cur.x0         = scale(tbl[i].mode, tbl[i].x0);
        cur.x1         = scale(tbl[i].mode, tbl[i].x1);
    endtask

    task automatic idle();
        bus.in_valid_i = 1'b0;
    endtask

    // Scoreboard: record each accepted transaction, discard everything on reset.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else if (bus.in_valid_i && bus.in_ready_o) begin
            exp_q.push_back(cur);
        end
    end

    always @(negedge clk) begin
        if (!reset && bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("sb_x0[%0d]", n_rx), bus.X0_o, e.x0);
                check($sformatf("sb_x1[%0d]", n_rx), bus.X1_o, e.x1);
                n_rx++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int rx0;
        int waited;

        //          mode  P      Q      W      X0     X1
        tbl[0] = '{1'b0, 12'd5,    12'd7,    12'd3,    12'd26,   12'd3313};
        tbl[1] = '{1'b1, 12'd5,    12'd7,    12'd3,    12'd12,   12'd3323};
        tbl[2] = '{1'b0, 12'd3328, 12'd1,    12'd1,    12'd0,    12'd3327};
        tbl[3] = '{1'b0, 12'd0,    12'd3328, 12'd3328, 12'd1,    12'd3328};
        tbl[4] = '{1'b1, 12'd3328, 12'd3328, 12'd2,    12'd3327, 12'd0};
        tbl[5] = '{1'b1, 12'd0,    12'd1,    12'd1,    12'd1,    12'd3328};
        tbl[6] = '{1'b0, 12'd100,  12'd200,  12'd300,  12'd178,  12'd22};
        tbl[7] = '{1'b1, 12'd1000, 12'd3000, 12'd17,   12'd671,  12'd2619};
        tbl[8] = '{1'b0, 12'd1234, 12'd2345, 12'd3000, 12'd2057, 12'd411};
        tbl[9] = '{1'b1, 12'd3000, 12'd1000, 12'd3328, 12'd671,  12'd1329};

        reset           = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.mode_i      = 1'b0;
        bus.P_i         = '0;
        bus.Q_i         = '0;
        bus.W_i         = '0;
        bus.out_ready_i = 1'b0;
        cur             = '{12'd0, 12'd0};

        step();
        step();
        check("rst_out_valid", bus.out_valid_o, 1'b0);
        check("rst_x0", bus.X0_o, 12'd0);
        check("rst_x1", bus.X1_o, 12'd0);
        check("rst_in_ready", bus.in_ready_o, 1'b1);
        reset           = 1'b0;
        bus.out_ready_i = 1'b1;

        // Single transactions: 3-cycle latency, one-cycle valid pulse, exact results.
        for (int i = 0; i < 4; i++) begin
            drive(i);
            step();
            idle();
            check($sformatf("lat_v1[%0d]", i), bus.out_valid_o, 1'b0);
            step();
            check($sformatf("lat_v2[%0d]", i), bus.out_valid_o, 1'b0);
            step();
            check($sformatf("lat_v3[%0d]", i), bus.out_valid_o, 1'b1);
            check($sformatf("dir_x0[%0d]", i), bus.X0_o, scale(tbl[i].mode, tbl[i].x0));
            check($sformatf("dir_x1[%0d]", i), bus.X1_o, scale(tbl[i].mode, tbl[i].x1));
            step();
            check($sformatf("pulse_end[%0d]", i), bus.out_valid_o, 1'b0);
        end

        // Back-to-back stream of the whole table: valid must stay high for 10 cycles.
        rx0 = n_rx;
        for (int i = 0; i < 12; i++) begin
            if (i < 10) drive(i);
            else        idle();
            step();
            if (i >= 2) check($sformatf("stream_valid[%0d]", i - 2), bus.out_valid_o, 1'b1);
        end
        step();
        check("stream_tail_valid", bus.out_valid_o, 1'b0);
        check("stream_count", n_rx - rx0, 10);

        // Backpressure with a full pipe: outputs frozen on tbl[0], input refused.
        rx0 = n_rx;
        drive(0);
        step();
        drive(1);
        step();
        drive(2);
        step();
        drive(3);
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("bp_in_ready[%0d]", k), bus.in_ready_o, 1'b0);
            check($sformatf("bp_valid[%0d]", k), bus.out_valid_o, 1'b1);
            check($sformatf("bp_x0[%0d]", k), bus.X0_o, scale(tbl[0].mode, tbl[0].x0));
            check($sformatf("bp_x1[%0d]", k), bus.X1_o, scale(tbl[0].mode, tbl[0].x1));
        end
        bus.out_ready_i = 1'b1;
        step();
        idle();
        waited = 0;
        while ((exp_q.size() != 0 || bus.out_valid_o) && waited < 12) begin
            step();
            waited++;
        end
        check("bp_drain_pending", exp_q.size(), 0);
        check("bp_count", n_rx - rx0, 4);

        // Reset with three transactions in flight: nothing may emerge afterwards.
        drive(4);
        step();
        drive(5);
        step();
        drive(6);
        step();
        idle();
        bus.out_ready_i = 1'b0;
        reset           = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_out_valid", bus.out_valid_o, 1'b0);
        check("mid_rst_x0", bus.X0_o, 12'd0);
        check("mid_rst_x1", bus.X1_o, 12'd0);
        check("mid_rst_in_ready", bus.in_ready_o, 1'b1);
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("no_stale[%0d]", k), bus.out_valid_o, 1'b0);
        end

        // Recovery after reset.
        drive(7);
        step();
        idle();
        step();
        step();
        check("post_rst_valid", bus.out_valid_o, 1'b1);
        check("post_rst_x0", bus.X0_o, scale(tbl[7].mode, tbl[7].x0));
        check("post_rst_x1", bus.X1_o, scale(tbl[7].mode, tbl[7].x1));
        step();
        step();
        check("final_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bfu_pipe.md
Name: bfu_pipe

Overview:
Parametrised, pipelined modular butterfly unit for NTT/INTT datapaths.
- Supports Cooley-Tukey (CT, forward) and Gentleman-Sande (GS, inverse) butterflies, selected per transaction.
- All arithmetic is reduced mod MOD.
- Sits between the coefficient memory read port and the write-back path.
- Uses a valid/ready handshake on both sides, so the controller can stall it.

Parameters:
DATA_WIDTH, 12, width of P, Q, W and of both results; must satisfy MOD < 2^DATA_WIDTH.
MOD, 3329, odd prime modulus; all operands and results lie in [0, MOD-1].
LATENCY, 3, fixed pipeline depth; only the value 3 is supported. The parameter is exposed for checking only.

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  synchronous, active-high reset
in_valid_i  in  1  input transaction valid
in_ready_o  out  1  block can accept an input this cycle
mode_i  in  1  0 = CT, 1 = GS; sampled with the transaction
P_i  in  DATA_WIDTH  operand P, < MOD
Q_i  in  DATA_WIDTH  operand Q, < MOD
W_i  in  DATA_WIDTH  twiddle factor, < MOD
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts the result
X0_o  out  DATA_WIDTH  first result
X1_o  out  DATA_WIDTH  second result

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, on reset_i sampled at the rising edge of clk_i.
- Reset values:
  - All stage valid bits clear.
  - out_valid_o = 0; X0_o = X1_o = 0.
  - in_ready_o = 1 in the first cycle after reset.
- Reset mid-operation: every in-flight transaction is discarded. No partial result is ever presented.
- Pipeline: three register stages S1, S2, S3; S3 drives the outputs.
  - advance = !out_valid_o || out_ready_i.
  - in_ready_o = advance (combinational).
  - When advance = 1, all stages shift by one. An input is accepted when in_valid_i && in_ready_o.
  - When advance = 0, every stage holds its contents, and X0_o, X1_o and out_valid_o stay stable.
- Latency: an input accepted at edge N appears at the outputs after edge N+3 if there is no stall. Every stall cycle adds one.
- Throughput: one transaction per cycle, with no bubbles while out_ready_i = 1.
- Ordering: results leave in strict input order.
- S1 (operand prepare):
  - CT: computes prod = Q*W (2*DATA_WIDTH bits).
  - GS: computes s = P+Q and d = P-Q+MOD.
  - mode and P are registered alongside.
- S2 (reduce):
  - CT: t = prod mod MOD; a = P+t; b = P-t+MOD.
  - GS: a = s; b = (d mod MOD)*W.
- S3 (final reduce):
  - CT: X0 = a mod MOD; X1 = b mod MOD.
  - GS: X0 = a mod MOD; X1 = b mod MOD.
  - Every single-subtract reduction uses a conditional subtract (x >= MOD ? x-MOD : x). Full products use a modulo reduction.
- Results are always in [0, MOD-1]. No output ever equals MOD.
- Operands >= MOD are a protocol violation. The bench does not drive them, and the output is unspecified in that case.
- Bubbles (stage valid = 0) still shift, but their data is don't-care. The output data registers update only when a valid transaction enters S3.
- Simultaneous accept and drain in the same cycle with out_valid_o = 1 and out_ready_i = 1: both happen, and the pipe stays full.

Optional Feature:
BFU_SCALE_EN
- Defined: in GS mode, both outputs are multiplied by 2^-1 mod MOD in S3.
  - Rule for value x: x even gives x/2; x odd gives (x+MOD)/2.
  - This folds the INTT 1/2 scaling into the butterfly.
  - CT mode is unaffected, and latency is unchanged.
- Not defined: no scaling logic; GS outputs are unscaled.

Decomposition:
- Package bfu_pkg holds:
  - typedef bfu_mode_e {BFU_CT = 1'b0, BFU_GS = 1'b1};
  - stage-record typedef structs for S1 and S2 payloads;
  - constant BFU_LATENCY = 3;
  - function mod_csub(x) for the conditional subtract.
- One natural sub-module, bfu_modmul: registered (a*b) mod MOD. It is instantiated for the CT product path and the GS difference path.

Test Plan (MOD=3329, DATA_WIDTH=12, out_ready_i=1 unless stated):
1. CT P=5, Q=7, W=3 -> after 3 cycles X0=26, X1=3313, out_valid_o pulses for 1 cycle.
2. GS P=5, Q=7, W=3 -> X0=12, X1=3323. With BFU_SCALE_EN -> X0=6, X1=3326.
3. Wrap-around, CT P=3328, Q=1, W=1 -> X0=0, X1=3327. Also CT P=0, Q=3328, W=3328 -> X0=1, X1=3328.
4. Back-to-back stream of 8 mixed CT/GS inputs -> 8 results on consecutive cycles, in order, each matching the reference model.
5. Backpressure: hold out_ready_i=0 for 4 cycles while the pipe is full.
   - in_ready_o=0 and the outputs are stable for those cycles.
   - After release, results drain in order with no loss or duplication.
6. Assert reset_i for 1 cycle with 3 transactions in flight -> next cycle out_valid_o=0, X0_o=X1_o=0, in_ready_o=1; no stale result ever appears.
